sissue_ctrl: RTL

Scoreboard-based issue controller between the scalar decoder and the execute stage. Tracks registers with outstanding writes, stalls decode on RAW/WAW hazards and in-flight limits, and holds issue while a branch or jump is unresolved. Provides the single valid/ready issue handshake to execute and a flush path for wrong-path instructions.

---
 rtl/sissue_ctrl_if.sv | 43 ++++
 rtl/sissue_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/sissue_ctrl_if.sv
// Issue-controller bus: decoder request, execute handshake, writeback,
// branch resolution and status outputs bundled for one controller.
interface sissue_ctrl_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   dec_valid_i;
    logic [4:0]             dec_rs1_i;
    logic [4:0]             dec_rs2_i;
    logic [4:0]             dec_rd_i;
    logic                   dec_uses_rs1_i;
    logic                   dec_uses_rs2_i;
    logic                   dec_reg_write_i;
    logic                   dec_ctrl_xfer_i;
    logic                   dec_ready_o;
    logic                   issue_valid_o;
    logic                   issue_ready_i;
    logic                   wb_valid_i;
    logic [4:0]             wb_rd_i;
    logic                   resolve_valid_i;
    logic                   resolve_flush_i;
    logic [31:0]            pending_o;
    logic [3:0]             inflight_o;
    logic                   err_o;
    logic [STALL_CNT_W-1:0] stall_cnt_o;

    // Pipeline side: decoder, execute, writeback and branch unit.
    modport master (
        output dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rd_i, dec_uses_rs1_i,
               dec_uses_rs2_i, dec_reg_write_i, dec_ctrl_xfer_i, issue_ready_i,
               wb_valid_i, wb_rd_i, resolve_valid_i, resolve_flush_i,
        input  dec_ready_o, issue_valid_o, pending_o, inflight_o, err_o,
               stall_cnt_o
    );

    // Controller side.
    modport slave (
        input  dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rd_i, dec_uses_rs1_i,
               dec_uses_rs2_i, dec_reg_write_i, dec_ctrl_xfer_i, issue_ready_i,
               wb_valid_i, wb_rd_i, resolve_valid_i, resolve_flush_i,
        output dec_ready_o, issue_valid_o, pending_o, inflight_o, err_o,
               stall_cnt_o
    );
endinterface

// File: rtl/sissue_ctrl.sv
// Scoreboard issue controller: tracks outstanding register writes, stalls
// decode on RAW/WAW/in-flight hazards, and holds issue behind unresolved
// control transfers with a one-cycle flush bubble on redirect.
module sissue_ctrl #(
    parameter int MAX_INFLIGHT = 4,
    parameter int STALL_CNT_W  = 16
) (
    input logic         clk,
    input logic         rst_n,
    sissue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, WAIT_RES, FLUSH} state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       reg_write;
        logic       ctrl_xfer;
    } dec_req_t;

    state_t                 state;
    logic [31:0]            busy;
    logic [31:0]            busy_nxt;
    logic [3:0]             inflight;
    logic                   err;
    logic [STALL_CNT_W-1:0] stall_cnt;

    dec_req_t req;
    logic     rd_tracked, hazard, issue_valid, fire, dec_ready;
    logic     set_en, wb_nz, clr_en, wb_err;

    assign req = '{valid:     bus.dec_valid_i,
                   rs1:       bus.dec_rs1_i,
                   rs2:       bus.dec_rs2_i,
                   rd:        bus.dec_rd_i,
                   uses_rs1:  bus.dec_uses_rs1_i,
                   uses_rs2:  bus.dec_uses_rs2_i,
                   reg_write: bus.dec_reg_write_i,
                   ctrl_xfer: bus.dec_ctrl_xfer_i};

    // x0 writes are never tracked, so they neither consume a slot nor WAW-stall.
    assign rd_tracked  = req.reg_write & (req.rd != 5'd0);
    // Hazard uses registered busy only: a same-cycle writeback does not bypass.
    assign hazard      = (req.uses_rs1 & busy[req.rs1])
                       | (req.uses_rs2 & busy[req.rs2])
                       | (rd_tracked & (busy[req.rd] | (inflight == 4'(MAX_INFLIGHT))));
    assign issue_valid = req.valid & ~hazard & (state == RUN);
    assign fire        = issue_valid & bus.issue_ready_i;

    assign set_en = fire & rd_tracked;
    assign wb_nz  = bus.wb_valid_i & (bus.wb_rd_i != 5'd0);
    assign clr_en = wb_nz & busy[bus.wb_rd_i];
    assign wb_err = wb_nz & ~busy[bus.wb_rd_i];

    // Decode advances on issue or when idle; FLUSH swallows the wrong-path instruction.
    always_comb begin
        dec_ready = 1'b1;
        case (state)
            RUN:      dec_ready = fire | ~req.valid;
            WAIT_RES: dec_ready = ~req.valid;
            default:  dec_ready = 1'b1;
        endcase
    end

    // Next busy map: clear on writeback, then set on issue so a set always wins.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[bus.wb_rd_i] = 1'b0;
        if (set_en) busy_nxt[req.rd]      = 1'b1;
    end

    // Scoreboard, in-flight count and sticky writeback error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            inflight <= inflight + 4'(set_en) - 4'(clr_en);
            if (wb_err) err <= 1'b1;
        end
    end

    // Control-transfer tracking: hold issue until resolve, bubble once on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:      if (fire && req.ctrl_xfer) state <= WAIT_RES;
                WAIT_RES: if (bus.resolve_valid_i)
                              state <= bus.resolve_flush_i ? FLUSH : RUN;
                default:  state <= RUN;
            endcase
        end
    end

    // Saturating count of cycles a presented instruction was hazard-stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (req.valid && state == RUN && hazard && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign bus.issue_valid_o = issue_valid;
    assign bus.dec_ready_o   = dec_ready;
    assign bus.pending_o     = busy;
    assign bus.inflight_o    = inflight;
    assign bus.err_o         = err;
    assign bus.stall_cnt_o   = stall_cnt;
endmodule
